// File: rtl/instruction_decoder_core.sv
// rtl/instruction_decoder_core.sv - single-cycle registered instruction decoder (READ/WRITE/GO/NOP)
module instruction_decoder_core #(
    parameter int INPUT_SIGNAL_LENGTH  = 32,
    parameter int WRITE_ADDRESS_LENGTH = 15,
    parameter int WRITE_DATA_LENGTH    = 15,
    parameter int READ_ADDRESS_LENGTH  = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [INPUT_SIGNAL_LENGTH-1:0]  input_signal,
    output logic                            wr_en,
    output logic                            rd_en,
    output logic                            go,
    output logic [WRITE_ADDRESS_LENGTH-1:0] wr_addr,
    output logic [WRITE_DATA_LENGTH-1:0]    wr_data,
    output logic [READ_ADDRESS_LENGTH-1:0]  rd_start_addr,
    output logic [READ_ADDRESS_LENGTH-1:0]  rd_end_addr,
    output logic                            cmd_err
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_GO    = 2'b11;

    // Fixed field positions inside the instruction word
    logic [1:0]  opcode;
    logic [14:0] field_a;
    logic [14:0] field_b;

    assign opcode  = input_signal[31:30];
    assign field_a = input_signal[29:15];
    assign field_b = input_signal[14:0];

    logic                            wr_en_q, wr_en_d;
    logic                            rd_en_q, rd_en_d;
    logic                            go_q, go_d;
    logic                            cmd_err_q, cmd_err_d;
    logic [WRITE_ADDRESS_LENGTH-1:0] wr_addr_q, wr_addr_d;
    logic [WRITE_DATA_LENGTH-1:0]    wr_data_q, wr_data_d;
    logic [READ_ADDRESS_LENGTH-1:0]  rd_start_q, rd_start_d;
    logic [READ_ADDRESS_LENGTH-1:0]  rd_end_q, rd_end_d;

    // Decode the presented instruction into next-state strobes and field registers
    always_comb begin
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        go_d       = 1'b0;
        cmd_err_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_start_d = rd_start_q;
        rd_end_d   = rd_end_q;
        if (in_valid) begin
            case (opcode)
                OP_READ: begin
                    // An inverted range is rejected without disturbing the last good range
                    if (field_a <= field_b) begin
                        rd_en_d    = 1'b1;
                        rd_start_d = READ_ADDRESS_LENGTH'(field_a);
                        rd_end_d   = READ_ADDRESS_LENGTH'(field_b);
                    end else begin
                        cmd_err_d  = 1'b1;
                    end
                end
                OP_WRITE: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = WRITE_ADDRESS_LENGTH'(field_a);
                    wr_data_d = WRITE_DATA_LENGTH'(field_b);
                end
                OP_GO: begin
                    go_d = 1'b1;
                end
                OP_NOP: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Register all outputs; reset wins over any instruction presented on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            go_q       <= 1'b0;
            cmd_err_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_start_q <= '0;
            rd_end_q   <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            go_q       <= go_d;
            cmd_err_q  <= cmd_err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_start_q <= rd_start_d;
            rd_end_q   <= rd_end_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign rd_en         = rd_en_q;
    assign go            = go_q;
    assign cmd_err       = cmd_err_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign rd_start_addr = rd_start_q;
    assign rd_end_addr   = rd_end_q;

endmodule

// File: tb/tb_instruction_decoder_core.sv
// tb/tb_instruction_decoder_core.sv - table-driven self-checking bench for instruction_decoder_core
module tb_instruction_decoder_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] input_signal;
    logic        wr_en, rd_en, go, cmd_err;
    logic [14:0] wr_addr, wr_data, rd_start_addr, rd_end_addr;

    int n_checks;
    int n_fail;

    instruction_decoder_core dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .input_signal  (input_signal),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .go            (go),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_start_addr (rd_start_addr),
        .rd_end_addr   (rd_end_addr),
        .cmd_err       (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strb = {wr_en, rd_en, go, cmd_err}
    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] instr;
        logic [3:0]  strb;
        logic [14:0] wa;
        logic [14:0] wd;
        logic [14:0] rs;
        logic [14:0] re;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [14:0] a, input logic [14:0] b);
        return {op, a, b};
    endfunction

    task automatic add(input logic r, input logic v, input logic [31:0] ins, input logic [3:0] s,
                       input logic [14:0] wa, input logic [14:0] wd,
                       input logic [14:0] rs, input logic [14:0] re);
        vec_t t;
        t.rst = r; t.vld = v; t.instr = ins; t.strb = s;
        t.wa = wa; t.wd = wd; t.rs = rs; t.re = re;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] s,
                             input logic [14:0] wa, input logic [14:0] wd,
                             input logic [14:0] rs, input logic [14:0] re);
        check({tag, " strobes"}, {28'd0, wr_en, rd_en, go, cmd_err}, {28'd0, s});
        check({tag, " wr_addr"}, {17'd0, wr_addr}, {17'd0, wa});
        check({tag, " wr_data"}, {17'd0, wr_data}, {17'd0, wd});
        check({tag, " rd_start_addr"}, {17'd0, rd_start_addr}, {17'd0, rs});
        check({tag, " rd_end_addr"}, {17'd0, rd_end_addr}, {17'd0, re});
        check({tag, " onehot"}, {31'd0, ($countones({wr_en, rd_en, go, cmd_err}) <= 1)}, 32'd1);
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] ins);
        rst = r;
        in_valid = v;
        input_signal = ins;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        input_signal = '0;

        //   rst   vld   instruction                          strb     wa       wd       rs       re
        add(1'b1, 1'b1, mk(2'b10, 15'd5, 15'h7FFF),         4'b0000, 15'd0,    15'd0,   15'd0,   15'd0);
        add(1'b1, 1'b0, mk(2'b00, 15'd0, 15'd0),            4'b0000, 15'd0,    15'd0,   15'd0,   15'd0);
        add(1'b0, 1'b1, 32'b01_001000010000100_010000100011100,
                                                            4'b0100, 15'd0,    15'd0,   15'd4228, 15'd8476);
        add(1'b0, 1'b1, mk(2'b10, 15'd5, 15'h7FFF),         4'b1000, 15'd5,    15'd32767, 15'd4228, 15'd8476);
        add(1'b0, 1'b1, mk(2'b01, 15'd10, 15'd3),           4'b0001, 15'd5,    15'd32767, 15'd4228, 15'd8476);
        add(1'b0, 1'b1, mk(2'b01, 15'd7, 15'd7),            4'b0100, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b1, mk(2'b11, 15'd100, 15'd200),        4'b0010, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b1, mk(2'b11, 15'd100, 15'd200),        4'b0010, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b1, mk(2'b11, 15'd100, 15'd200),        4'b0010, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b0, mk(2'b10, 15'd1, 15'd2),            4'b0000, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b0, mk(2'b01, 15'd0, 15'd1),            4'b0000, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b0, mk(2'b11, 15'd0, 15'd1),            4'b0000, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b1, mk(2'b00, 15'd3, 15'd4),            4'b0000, 15'd5,    15'd32767, 15'd7,    15'd7);
        add(1'b0, 1'b1, mk(2'b10, 15'h7FFF, 15'd0),         4'b1000, 15'h7FFF, 15'd0,     15'd7,    15'd7);
        add(1'b0, 1'b1, mk(2'b10, 15'h7FFF, 15'd0),         4'b1000, 15'h7FFF, 15'd0,     15'd7,    15'd7);
        add(1'b0, 1'b1, mk(2'b01, 15'd0, 15'h7FFF),         4'b0100, 15'h7FFF, 15'd0,     15'd0,    15'h7FFF);
        add(1'b0, 1'b1, mk(2'b01, 15'h7FFF, 15'd0),         4'b0001, 15'h7FFF, 15'd0,     15'd0,    15'h7FFF);
        add(1'b0, 1'b1, mk(2'b01, 15'd8, 15'd9),            4'b0100, 15'h7FFF, 15'd0,     15'd8,    15'd9);
        add(1'b1, 1'b1, mk(2'b01, 15'd1, 15'd2),            4'b0000, 15'd0,    15'd0,     15'd0,    15'd0);
        add(1'b0, 1'b1, mk(2'b10, 15'd9, 15'd9),            4'b1000, 15'd9,    15'd9,     15'd0,    15'd0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].vld, vq[i].instr);
            check_all($sformatf("vec%0d", i), vq[i].strb, vq[i].wa, vq[i].wd, vq[i].rs, vq[i].re);
        end

        // Strobe is exactly one cycle: a WRITE followed by idle drops wr_en and holds registers
        step(1'b0, 1'b1, mk(2'b10, 15'd20, 15'd21));
        check_all("seq_wr", 4'b1000, 15'd20, 15'd21, 15'd0, 15'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, mk(2'(k), 15'd1, 15'd0));
            check_all($sformatf("seq_idle%0d", k), 4'b0000, 15'd20, 15'd21, 15'd0, 15'd0);
        end

        // Alternating back-to-back READ/WRITE/GO/bad-READ, each strobe in its own cycle
        step(1'b0, 1'b1, mk(2'b01, 15'd2, 15'd30));
        check_all("seq_b2b_rd", 4'b0100, 15'd20, 15'd21, 15'd2, 15'd30);
        step(1'b0, 1'b1, mk(2'b10, 15'd40, 15'd41));
        check_all("seq_b2b_wr", 4'b1000, 15'd40, 15'd41, 15'd2, 15'd30);
        step(1'b0, 1'b1, mk(2'b11, 15'd0, 15'd0));
        check_all("seq_b2b_go", 4'b0010, 15'd40, 15'd41, 15'd2, 15'd30);
        step(1'b0, 1'b1, mk(2'b01, 15'd31, 15'd30));
        check_all("seq_b2b_err", 4'b0001, 15'd40, 15'd41, 15'd2, 15'd30);

        // GO discarded by reset, then accepted on the first edge with rst low
        step(1'b1, 1'b1, mk(2'b11, 15'd0, 15'd0));
        check_all("seq_rst_go", 4'b0000, 15'd0, 15'd0, 15'd0, 15'd0);
        step(1'b0, 1'b1, mk(2'b11, 15'd0, 15'd0));
        check_all("seq_go_after_rst", 4'b0010, 15'd0, 15'd0, 15'd0, 15'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
